// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the PC, the IF/ID pipeline buffer and a small
// circular return-address stack (RAS) used by CALL/RET. The decode-stage
// controller steers it through PCSrc/PCsrcJType (next-PC select), killF
// (flush the instruction being fetched), stall (freeze everything), RRSrc
// (CALL in ID: push return address) and ret_in (RET in ID: pop).
//
// Optional feature: define FETCH_PERF_EN to add three saturating 16-bit
// performance counters (perf_fetched, perf_killed, perf_stalled).
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   imem_addr          instruction memory address (the PC register)
//   imem_rdata         instruction at imem_addr (combinational read)
//   stall              hold PC, IF/ID and RAS; other controls ignored
//   killF              load a NOOP bubble into IF/ID instead of imem_rdata
//   PCSrc              00 seq, 01 branch, 10 FOR, 11 jump/return
//   PCsrcJType         with PCSrc=11: 0 jump_target, 1 RAS top
//   RRSrc, ret_in      RAS push (id_pc+1) / pop
//   branch_target, for_target, jump_target   redirect targets
//   id_inst, id_pc, id_valid                 IF/ID buffer contents
//   ras_underflow      one-cycle pulse on a pop of the empty RAS
//   perf_fetched, perf_killed, perf_stalled  (FETCH_PERF_EN only)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                PC_W      = 16,
  parameter int                INST_W    = 16,
  parameter logic [INST_W-1:0] NOOP_INST = 16'hF000,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  // Must be a power of two and at least 2 so the stack pointer wraps cleanly.
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              killF,
  input  logic [1:0]        PCSrc,
  input  logic              PCsrcJType,
  input  logic              RRSrc,
  input  logic              ret_in,
  input  logic [PC_W-1:0]   branch_target,
  input  logic [PC_W-1:0]   for_target,
  input  logic [PC_W-1:0]   jump_target,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_valid,
  output logic              ras_underflow
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_killed,
  output logic [15:0]       perf_stalled
`endif
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  next_pc;
  logic [PC_W-1:0]  ret_addr;
  logic [PC_W-1:0]  ras_top;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_top_ptr;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;

  assign imem_addr = pc;

  // ras_ptr is the next free slot, so the top entry sits one below it. Once
  // the stack is full the pointer lands on the oldest entry, which is exactly
  // the one a further push should overwrite. An empty stack reads as
  // RESET_PC so a stray RET restarts the program rather than jumping to junk.
  always_comb begin
    ras_top_ptr = ras_ptr - PTR_W'(1);
    ras_empty   = (ras_count == '0);
    ras_full    = (ras_count == CNT_W'(RAS_DEPTH));
    ras_top     = ras_empty ? RESET_PC : ras_mem[ras_top_ptr];
    ret_addr    = id_pc + PC_W'(1);
  end

  // Next-PC select. The RET target is read from the stack before the pop
  // that happens on the same edge.
  always_comb begin
    next_pc = pc + PC_W'(1);
    unique case (PCSrc)
      2'b00: next_pc = pc + PC_W'(1);
      2'b01: next_pc = branch_target;
      2'b10: next_pc = for_target;
      2'b11: next_pc = PCsrcJType ? ras_top : jump_target;
    endcase
  end

  // PC and IF/ID buffer. A stall freezes both and masks every control input,
  // because the instruction in ID re-issues its controls on the next cycle.
  // A kill still records the current PC in id_pc, only the instruction is
  // replaced by a NOOP bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      id_inst  <= NOOP_INST;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      pc    <= next_pc;
      id_pc <= pc;
      if (killF) begin
        id_inst  <= NOOP_INST;
        id_valid <= 1'b0;
      end else begin
        id_inst  <= imem_rdata;
        id_valid <= 1'b1;
      end
    end
  end

  // Return-address stack. A simultaneous push and pop replaces the top in
  // place (or creates a single entry if the stack was empty). A pop of the
  // empty stack leaves pointer and count alone and raises ras_underflow,
  // which drops again on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr       <= '0;
      ras_count     <= '0;
      ras_underflow <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      ras_underflow <= 1'b0;
      if (!stall) begin
        if (RRSrc && ret_in) begin
          if (ras_empty) begin
            ras_mem[ras_ptr] <= ret_addr;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            ras_count        <= CNT_W'(1);
          end else begin
            ras_mem[ras_top_ptr] <= ret_addr;
          end
        end else if (RRSrc) begin
          ras_mem[ras_ptr] <= ret_addr;
          ras_ptr          <= ras_ptr + PTR_W'(1);
          if (!ras_full) begin
            ras_count <= ras_count + CNT_W'(1);
          end
        end else if (ret_in) begin
          if (ras_empty) begin
            ras_underflow <= 1'b1;
          end else begin
            ras_ptr   <= ras_top_ptr;
            ras_count <= ras_count - CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: every cycle out of reset lands in exactly one of
  // the three buckets. Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
      perf_stalled <= '0;
    end else if (stall) begin
      if (perf_stalled != 16'hFFFF) begin
        perf_stalled <= perf_stalled + 16'd1;
      end
    end else if (killF) begin
      if (perf_killed != 16'hFFFF) begin
        perf_killed <= perf_killed + 16'd1;
      end
    end else begin
      if (perf_fetched != 16'hFFFF) begin
        perf_fetched <= perf_fetched + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed, table-driven bench for fetch_unit. Instruction memory is modelled
// as inst_of(addr) so id_inst and id_pc carry different values. Each table
// record holds the controls for one cycle and the outputs expected just after
// the following rising edge. Hand-written sequences cover reset in the middle
// of operation. With FETCH_PERF_EN defined the perf counters are checked too.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [15:0] NOOP = 16'hF000;

  typedef struct {
    logic        st;
    logic        kf;
    logic [1:0]  src;
    logic        jt;
    logic        rr;
    logic        rt;
    logic [15:0] br_t;
    logic [15:0] for_t;
    logic [15:0] jmp_t;
    logic [15:0] exp_addr;
    logic [15:0] exp_inst;
    logic [15:0] exp_pc;
    logic        exp_valid;
    logic        exp_uf;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        killF;
  logic [1:0]  PCSrc;
  logic        PCsrcJType;
  logic        RRSrc;
  logic        ret_in;
  logic [15:0] branch_target;
  logic [15:0] for_target;
  logic [15:0] jump_target;
  logic [15:0] id_inst;
  logic [15:0] id_pc;
  logic        id_valid;
  logic        ras_underflow;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_killed;
  logic [15:0] perf_stalled;
`endif

  int checks = 0;
  int passes = 0;
  int exp_fetched = 0;
  int exp_killed = 0;
  int exp_stalled = 0;

  vec_t vecs [41];

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return a ^ 16'h3C00;
  endfunction

  // Unselected targets get distinct junk values so a wrong mux leg shows up.
  function automatic vec_t mk(input logic st, input logic kf, input logic [1:0] src,
                              input logic jt, input logic rr, input logic rt,
                              input logic [15:0] tgt, input logic [15:0] ea,
                              input logic [15:0] ei, input logic [15:0] ep,
                              input logic ev, input logic eu);
    vec_t v;
    v.st = st; v.kf = kf; v.src = src; v.jt = jt; v.rr = rr; v.rt = rt;
    v.br_t  = (src == 2'b01) ? tgt : 16'h0BB0;
    v.for_t = (src == 2'b10) ? tgt : 16'h0FF0;
    v.jmp_t = (src == 2'b11) ? tgt : 16'h0AA0;
    v.exp_addr = ea; v.exp_inst = ei; v.exp_pc = ep;
    v.exp_valid = ev; v.exp_uf = eu;
    return v;
  endfunction

  assign imem_rdata = inst_of(imem_addr);

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .killF         (killF),
    .PCSrc         (PCSrc),
    .PCsrcJType    (PCsrcJType),
    .RRSrc         (RRSrc),
    .ret_in        (ret_in),
    .branch_target (branch_target),
    .for_target    (for_target),
    .jump_target   (jump_target),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_valid      (id_valid),
    .ras_underflow (ras_underflow)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_killed   (perf_killed),
    .perf_stalled  (perf_stalled)
`endif
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of controls on the falling edge, let the rising edge
  // happen, then sample 1 ns later. The perf model tracks the same cycle.
  task automatic applyStimulus(input vec_t v, input logic rst);
    @(negedge clk);
    reset         = rst;
    stall         = v.st;
    killF         = v.kf;
    PCSrc         = v.src;
    PCsrcJType    = v.jt;
    RRSrc         = v.rr;
    ret_in        = v.rt;
    branch_target = v.br_t;
    for_target    = v.for_t;
    jump_target   = v.jmp_t;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_fetched = 0; exp_killed = 0; exp_stalled = 0;
    end else if (v.st) begin
      exp_stalled++;
    end else if (v.kf) begin
      exp_killed++;
    end else begin
      exp_fetched++;
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    cmp({tag, " imem_addr"}, imem_addr, v.exp_addr);
    cmp({tag, " id_inst"}, id_inst, v.exp_inst);
    cmp({tag, " id_pc"}, id_pc, v.exp_pc);
    cmp({tag, " id_valid"}, {15'd0, id_valid}, {15'd0, v.exp_valid});
    cmp({tag, " ras_underflow"}, {15'd0, ras_underflow}, {15'd0, v.exp_uf});
  endtask

  task automatic checkPerf(input string tag);
`ifdef FETCH_PERF_EN
    cmp({tag, " perf_fetched"}, perf_fetched, 16'(exp_fetched));
    cmp({tag, " perf_killed"}, perf_killed, 16'(exp_killed));
    cmp({tag, " perf_stalled"}, perf_stalled, 16'(exp_stalled));
`else
    $display("[TB] %s: perf counters not built", tag);
`endif
  endtask

  initial begin
    vec_t idle;
    vec_t v;

    // Sequential fetch after reset.
    vecs[0]  = mk(0,0,0,0,0,0, 16'h0000, 16'h0001, inst_of(16'h0000), 16'h0000, 1, 0);
    vecs[1]  = mk(0,0,0,0,0,0, 16'h0000, 16'h0002, inst_of(16'h0001), 16'h0001, 1, 0);
    vecs[2]  = mk(0,0,0,0,0,0, 16'h0000, 16'h0003, inst_of(16'h0002), 16'h0002, 1, 0);
    vecs[3]  = mk(0,0,0,0,0,0, 16'h0000, 16'h0004, inst_of(16'h0003), 16'h0003, 1, 0);
    vecs[4]  = mk(0,0,0,0,0,0, 16'h0000, 16'h0005, inst_of(16'h0004), 16'h0004, 1, 0);
    // Two stall cycles at PC=5, then resume.
    vecs[5]  = mk(1,0,0,0,0,0, 16'h0000, 16'h0005, inst_of(16'h0004), 16'h0004, 1, 0);
    vecs[6]  = mk(1,0,0,0,0,0, 16'h0000, 16'h0005, inst_of(16'h0004), 16'h0004, 1, 0);
    vecs[7]  = mk(0,0,0,0,0,0, 16'h0000, 16'h0006, inst_of(16'h0005), 16'h0005, 1, 0);
    // Killed branch to 0x40.
    vecs[8]  = mk(0,1,1,0,0,0, 16'h0040, 16'h0040, NOOP,              16'h0006, 0, 0);
    vecs[9]  = mk(0,0,0,0,0,0, 16'h0000, 16'h0041, inst_of(16'h0040), 16'h0040, 1, 0);
    // Jump to 0x10, CALL 0x80 from there, RET back to 0x11.
    vecs[10] = mk(0,1,3,0,0,0, 16'h0010, 16'h0010, NOOP,              16'h0041, 0, 0);
    vecs[11] = mk(0,0,0,0,0,0, 16'h0000, 16'h0011, inst_of(16'h0010), 16'h0010, 1, 0);
    vecs[12] = mk(0,1,3,0,1,0, 16'h0080, 16'h0080, NOOP,              16'h0011, 0, 0);
    vecs[13] = mk(0,0,0,0,0,0, 16'h0000, 16'h0081, inst_of(16'h0080), 16'h0080, 1, 0);
    vecs[14] = mk(0,1,3,1,0,1, 16'h0077, 16'h0011, NOOP,              16'h0081, 0, 0);
    vecs[15] = mk(0,0,0,0,0,0, 16'h0000, 16'h0012, inst_of(16'h0011), 16'h0011, 1, 0);
    // Stack is empty again: RET underflows to RESET_PC.
    vecs[16] = mk(0,1,3,1,0,1, 16'h0077, 16'h0000, NOOP,              16'h0012, 0, 1);
    vecs[17] = mk(0,0,0,0,0,0, 16'h0000, 16'h0001, inst_of(16'h0000), 16'h0000, 1, 0);
    // Stall masks kill and FOR redirect; redirect happens next cycle.
    vecs[18] = mk(1,1,2,0,0,0, 16'h0022, 16'h0001, inst_of(16'h0000), 16'h0000, 1, 0);
    vecs[19] = mk(0,1,2,0,0,0, 16'h0022, 16'h0022, NOOP,              16'h0001, 0, 0);
    vecs[20] = mk(0,0,0,0,0,0, 16'h0000, 16'h0023, inst_of(16'h0022), 16'h0022, 1, 0);
    // Stall masks a push: the following RET still finds an empty stack.
    vecs[21] = mk(1,0,0,0,1,0, 16'h0000, 16'h0023, inst_of(16'h0022), 16'h0022, 1, 0);
    vecs[22] = mk(0,1,3,1,0,1, 16'h0077, 16'h0000, NOOP,              16'h0023, 0, 1);
    vecs[23] = mk(0,0,0,0,0,0, 16'h0000, 16'h0001, inst_of(16'h0000), 16'h0000, 1, 0);
    // Five pushes (1..5) into a 4-deep stack, then five pops.
    vecs[24] = mk(0,0,0,0,1,0, 16'h0000, 16'h0002, inst_of(16'h0001), 16'h0001, 1, 0);
    vecs[25] = mk(0,0,0,0,1,0, 16'h0000, 16'h0003, inst_of(16'h0002), 16'h0002, 1, 0);
    vecs[26] = mk(0,0,0,0,1,0, 16'h0000, 16'h0004, inst_of(16'h0003), 16'h0003, 1, 0);
    vecs[27] = mk(0,0,0,0,1,0, 16'h0000, 16'h0005, inst_of(16'h0004), 16'h0004, 1, 0);
    vecs[28] = mk(0,0,0,0,1,0, 16'h0000, 16'h0006, inst_of(16'h0005), 16'h0005, 1, 0);
    vecs[29] = mk(0,1,3,1,0,1, 16'h0077, 16'h0005, NOOP,              16'h0006, 0, 0);
    vecs[30] = mk(0,1,3,1,0,1, 16'h0077, 16'h0004, NOOP,              16'h0005, 0, 0);
    vecs[31] = mk(0,1,3,1,0,1, 16'h0077, 16'h0003, NOOP,              16'h0004, 0, 0);
    vecs[32] = mk(0,1,3,1,0,1, 16'h0077, 16'h0002, NOOP,              16'h0003, 0, 0);
    vecs[33] = mk(0,1,3,1,0,1, 16'h0077, 16'h0000, NOOP,              16'h0002, 0, 1);
    vecs[34] = mk(0,0,0,0,0,0, 16'h0000, 16'h0001, inst_of(16'h0000), 16'h0000, 1, 0);
    // Push+pop together: create one entry (1), replace it (2), pop, underflow.
    vecs[35] = mk(0,0,0,0,1,1, 16'h0000, 16'h0002, inst_of(16'h0001), 16'h0001, 1, 0);
    vecs[36] = mk(0,0,0,0,1,1, 16'h0000, 16'h0003, inst_of(16'h0002), 16'h0002, 1, 0);
    vecs[37] = mk(0,1,3,1,0,1, 16'h0077, 16'h0002, NOOP,              16'h0003, 0, 0);
    vecs[38] = mk(0,1,3,1,0,1, 16'h0077, 16'h0000, NOOP,              16'h0002, 0, 1);
    // PC wraps from 0xFFFF to 0.
    vecs[39] = mk(0,1,3,0,0,0, 16'hFFFF, 16'hFFFF, NOOP,              16'h0000, 0, 0);
    vecs[40] = mk(0,0,0,0,0,0, 16'h0000, 16'h0000, inst_of(16'hFFFF), 16'hFFFF, 1, 0);

    idle = mk(0,0,0,0,0,0, 16'h0000, 16'h0000, NOOP, 16'h0000, 0, 0);

    // Reset for two edges and check the reset state.
    applyStimulus(idle, 1'b1);
    applyStimulus(idle, 1'b1);
    checkOutput(mk(0,0,0,0,0,0, 16'h0000, 16'h0000, NOOP, 16'h0000, 0, 0), "reset");
    checkPerf("reset");

    for (int i = 0; i < 41; i++) begin
      applyStimulus(vecs[i], 1'b0);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end
    checkPerf("table");

    // Reset in the middle of operation discards the pushed return address
    // and the redirect presented alongside it.
    v = mk(0,0,0,0,0,0, 16'h0000, 16'h0001, inst_of(16'h0000), 16'h0000, 1, 0);
    applyStimulus(v, 1'b0);
    checkOutput(v, "pre_reset_fetch");
    v = mk(0,0,0,0,1,0, 16'h0000, 16'h0002, inst_of(16'h0001), 16'h0001, 1, 0);
    applyStimulus(v, 1'b0);
    checkOutput(v, "pre_reset_push");
    v = mk(0,1,1,0,0,0, 16'h0055, 16'h0000, NOOP, 16'h0000, 0, 0);
    applyStimulus(v, 1'b1);
    checkOutput(v, "mid_reset");
    checkPerf("mid_reset");
    v = mk(0,1,3,1,0,1, 16'h0077, 16'h0000, NOOP, 16'h0000, 0, 1);
    applyStimulus(v, 1'b0);
    checkOutput(v, "post_reset_pop");
    v = mk(0,0,0,0,0,0, 16'h0000, 16'h0001, inst_of(16'h0000), 16'h0000, 1, 0);
    applyStimulus(v, 1'b0);
    checkOutput(v, "post_reset_fetch");
    checkPerf("final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
